// File: rtl/fsm_state_monitor_pkg.sv
// Shared encodings for the JK-toggle FSM monitor.
// Monitor FSM states plus the default lock target and hold length.
package fsm_state_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } mon_st_e;

  localparam logic [1:0] TARGET_DEF = 2'b11;
  localparam int         HOLD_DEF   = 3;
  localparam int         CNT_W_DEF  = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sync clear > load-1 > increment (sticks at max).
// Ports: clk, i_clr, i_load1, i_inc, o_q[W-1:0].
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_load1,
  input  logic         i_inc,
  output logic [W-1:0] o_q
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_q <= '0;
    end else if (i_load1) begin
      r_q <= ONE;
    end else if (i_inc && (r_q != '1)) begin
      r_q <= r_q + ONE;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fsm_state_monitor.sv
// Observer for the 2-bit JK-toggle FSM: change/transition/dwell/lock.
// Ports: clk, rst, en, y_b, y_a -> state_q, changed, trans_cnt, dwell, lock, lock_pulse.
module fsm_state_monitor
  import fsm_state_monitor_pkg::*;
#(
  parameter int         CNT_W  = CNT_W_DEF,
  parameter logic [1:0] TARGET = TARGET_DEF,
  parameter int         HOLD   = HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             y_b,
  input  logic             y_a,
  output logic [1:0]       state_q,
  output logic             changed,
  output logic [CNT_W-1:0] trans_cnt,
  output logic [CNT_W-1:0] dwell,
  output logic             lock,
  output logic             lock_pulse
);

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD);

  mon_st_e          r_st;
  mon_st_e          w_st_nxt;
  logic [1:0]       r_q;
  logic             r_chg;
  logic             r_lock;
  logic             r_pulse;

  logic [1:0]       w_cur;
  logic             w_diff;
  logic             w_tgt;
  logic [CNT_W-1:0] w_nd;
  logic             w_chg;
  logic             w_tr_inc;
  logic             w_dw_load1;
  logic             w_dw_inc;
  logic             w_upd_q;
  logic             w_lock_nxt;
  logic             w_pulse;

  assign w_cur  = {y_b, y_a};
  assign w_diff = (w_cur != r_q);
  assign w_tgt  = (w_cur == TARGET);

  // Dwell as it will be after this sample while tracking.
  always_comb begin
    w_nd = ONE;
    if (!w_diff) begin
      w_nd = (dwell == '1) ? dwell : dwell + ONE;
    end
  end

  always_comb begin
    w_st_nxt   = r_st;
    w_chg      = 1'b0;
    w_tr_inc   = 1'b0;
    w_dw_load1 = 1'b0;
    w_dw_inc   = 1'b0;
    w_upd_q    = 1'b0;
    w_lock_nxt = r_lock;
    w_pulse    = 1'b0;
    if (en) begin
      unique case (r_st)
        ST_IDLE: begin
          w_upd_q    = 1'b1;
          w_dw_load1 = 1'b1;
          if (w_tgt && (HOLD_C == ONE)) begin
            w_st_nxt   = ST_LOCKED;
            w_lock_nxt = 1'b1;
            w_pulse    = 1'b1;
          end else begin
            w_st_nxt = ST_TRACK;
          end
        end
        ST_TRACK: begin
          w_upd_q = 1'b1;
          if (w_diff) begin
            w_chg      = 1'b1;
            w_tr_inc   = 1'b1;
            w_dw_load1 = 1'b1;
          end else begin
            w_dw_inc = 1'b1;
          end
          if (w_tgt && (w_nd >= HOLD_C)) begin
            w_st_nxt   = ST_LOCKED;
            w_lock_nxt = 1'b1;
            w_pulse    = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (w_tgt) begin
            w_dw_inc = 1'b1;
          end else begin
            w_chg      = 1'b1;
            w_tr_inc   = 1'b1;
            w_dw_load1 = 1'b1;
            w_upd_q    = 1'b1;
            w_lock_nxt = 1'b0;
            w_st_nxt   = ST_TRACK;
          end
        end
        default: begin
          w_st_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st    <= ST_IDLE;
      r_q     <= 2'b00;
      r_chg   <= 1'b0;
      r_lock  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_st    <= w_st_nxt;
      r_chg   <= w_chg;
      r_lock  <= w_lock_nxt;
      r_pulse <= w_pulse;
      if (w_upd_q) begin
        r_q <= w_cur;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_trans (
    .clk     (clk),
    .i_clr   (rst),
    .i_load1 (1'b0),
    .i_inc   (w_tr_inc),
    .o_q     (trans_cnt)
  );

  sat_counter #(.W(CNT_W)) u_dwell (
    .clk     (clk),
    .i_clr   (rst),
    .i_load1 (w_dw_load1),
    .i_inc   (w_dw_inc),
    .o_q     (dwell)
  );

  assign state_q    = r_q;
  assign changed    = r_chg;
  assign lock       = r_lock;
  assign lock_pulse = r_pulse;

endmodule

// File: tb/tb_fsm_state_monitor.sv
// Bench for fsm_state_monitor: vector table, corner sequences, random vs model.
// Runs a default instance and a CNT_W=2 instance on shared stimulus.
module tb_fsm_state_monitor;

  localparam logic [1:0] TGT  = 2'b11;
  localparam int         HLD  = 3;
  localparam int         MX_D = 255;
  localparam int         MX_S = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       y_b = 1'b0;
  logic       y_a = 1'b0;

  logic [1:0] d_q,  s_q;
  logic       d_ch, s_ch;
  logic [7:0] d_tc, d_dw;
  logic [1:0] s_tc, s_dw;
  logic       d_lk, s_lk;
  logic       d_pl, s_pl;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  fsm_state_monitor u_dut (
    .clk(clk), .rst(rst), .en(en), .y_b(y_b), .y_a(y_a),
    .state_q(d_q), .changed(d_ch), .trans_cnt(d_tc),
    .dwell(d_dw), .lock(d_lk), .lock_pulse(d_pl)
  );

  fsm_state_monitor #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .y_b(y_b), .y_a(y_a),
    .state_q(s_q), .changed(s_ch), .trans_cnt(s_tc),
    .dwell(s_dw), .lock(s_lk), .lock_pulse(s_pl)
  );

  // Reference: "seen" = a sample has arrived since reset.
  typedef struct {
    bit       seen;
    bit       locked;
    bit [1:0] q;
    int       tc;
    int       dw;
    bit       chg;
    bit       pulse;
  } mdl_t;

  mdl_t md, ms;

  function automatic int smin(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit r, bit e,
                                 bit [1:0] c, int mx);
    mdl_t n;
    n = m;
    n.chg = 0;
    n.pulse = 0;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    if (!e) return n;
    if (!m.seen) begin
      n.seen = 1;
      n.q = c;
      n.dw = 1;
      n.locked = (HLD == 1) && (c == TGT);
      n.pulse = n.locked;
      return n;
    end
    if (m.locked) begin
      if (c == TGT) begin
        n.dw = smin(m.dw + 1, mx);
      end else begin
        n.chg = 1;
        n.tc = smin(m.tc + 1, mx);
        n.dw = 1;
        n.q = c;
        n.locked = 0;
      end
      return n;
    end
    if (c != m.q) begin
      n.chg = 1;
      n.tc = smin(m.tc + 1, mx);
      n.dw = 1;
    end else begin
      n.dw = smin(m.dw + 1, mx);
    end
    n.q = c;
    if (c == TGT && n.dw >= HLD) begin
      n.locked = 1;
      n.pulse = 1;
    end
    return n;
  endfunction

  task automatic cmp(string nm, mdl_t m, logic [1:0] q, logic ch,
                     logic [7:0] tc, logic [7:0] dw, logic lk, logic pl);
    n_vec++;
    if (q !== m.q || ch !== m.chg || int'(tc) != m.tc ||
        int'(dw) != m.dw || lk !== m.locked || pl !== m.pulse ||
        $isunknown({tc, dw})) begin
      n_mis++;
      $display("FAIL %s t=%0t: got q=%b ch=%b tc=%0d dw=%0d lk=%b pl=%b, want q=%b ch=%b tc=%0d dw=%0d lk=%b pl=%b",
               nm, $time, q, ch, tc, dw, lk, pl,
               m.q, m.chg, m.tc, m.dw, m.locked, m.pulse);
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic cycle(bit r, bit e, bit [1:0] c);
    rst = r;
    en = e;
    {y_b, y_a} = c;
    @(posedge clk);
    #1;
    md = mstep(md, r, e, c, MX_D);
    ms = mstep(ms, r, e, c, MX_S);
    cmp("dut", md, d_q, d_ch, d_tc, d_dw, d_lk, d_pl);
    cmp("sat", ms, s_q, s_ch, {6'd0, s_tc}, {6'd0, s_dw}, s_lk, s_pl);
  endtask

  typedef struct {
    bit       r;
    bit       e;
    bit       rnd;
    bit [1:0] c;
    bit [1:0] q;
    bit       ch;
    int       tc;
    int       dw;
    bit       lk;
    bit       pl;
  } vec_t;

  vec_t tbl[26];

  initial begin
    md = '{default: 0};
    ms = '{default: 0};

    tbl[0]  = '{1, 1, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0};
    tbl[3]  = '{0, 1, 0, 2'b00, 2'b00, 0, 0, 2, 0, 0};
    tbl[4]  = '{0, 1, 0, 2'b11, 2'b11, 1, 1, 1, 0, 0};
    tbl[5]  = '{0, 1, 0, 2'b11, 2'b11, 0, 1, 2, 0, 0};
    tbl[6]  = '{0, 1, 0, 2'b11, 2'b11, 0, 1, 3, 1, 1};
    tbl[7]  = '{0, 1, 0, 2'b11, 2'b11, 0, 1, 4, 1, 0};
    tbl[8]  = '{0, 1, 0, 2'b10, 2'b10, 1, 2, 1, 0, 0};
    tbl[9]  = '{0, 1, 0, 2'b11, 2'b11, 1, 3, 1, 0, 0};
    tbl[10] = '{0, 1, 0, 2'b11, 2'b11, 0, 3, 2, 0, 0};
    tbl[11] = '{0, 1, 0, 2'b11, 2'b11, 0, 3, 3, 1, 1};
    tbl[12] = '{0, 0, 0, 2'b00, 2'b11, 0, 3, 3, 1, 0};
    tbl[13] = '{0, 0, 0, 2'b01, 2'b11, 0, 3, 3, 1, 0};
    tbl[14] = '{0, 0, 0, 2'b10, 2'b11, 0, 3, 3, 1, 0};
    tbl[15] = '{0, 0, 0, 2'b00, 2'b11, 0, 3, 3, 1, 0};
    tbl[16] = '{0, 1, 0, 2'b11, 2'b11, 0, 3, 4, 1, 0};
    tbl[17] = '{1, 1, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0};
    tbl[18] = '{0, 1, 0, 2'b11, 2'b11, 0, 0, 1, 0, 0};
    tbl[19] = '{0, 1, 0, 2'b11, 2'b11, 0, 0, 2, 0, 0};
    tbl[20] = '{0, 1, 0, 2'b11, 2'b11, 0, 0, 3, 1, 1};
    tbl[21] = '{0, 1, 0, 2'b01, 2'b01, 1, 1, 1, 0, 0};
    tbl[22] = '{0, 1, 0, 2'b11, 2'b11, 1, 2, 1, 0, 0};
    tbl[23] = '{0, 1, 0, 2'b11, 2'b11, 0, 2, 2, 0, 0};
    tbl[24] = '{0, 1, 0, 2'b11, 2'b11, 0, 2, 3, 1, 1};
    tbl[25] = '{0, 0, 0, 2'b00, 2'b11, 0, 2, 3, 1, 0};

    for (int i = 0; i < 26; i++) begin
      bit [1:0] c;
      c = tbl[i].rnd ? 2'($urandom) : tbl[i].c;
      cycle(tbl[i].r, tbl[i].e, c);
      n_vec++;
      if (d_q !== tbl[i].q || d_ch !== tbl[i].ch ||
          int'(d_tc) != tbl[i].tc || int'(d_dw) != tbl[i].dw ||
          d_lk !== tbl[i].lk || d_pl !== tbl[i].pl) begin
        n_mis++;
        $display("FAIL tbl[%0d]: got q=%b ch=%b tc=%0d dw=%0d lk=%b pl=%b, want q=%b ch=%b tc=%0d dw=%0d lk=%b pl=%b",
                 i, d_q, d_ch, d_tc, d_dw, d_lk, d_pl,
                 tbl[i].q, tbl[i].ch, tbl[i].tc, tbl[i].dw,
                 tbl[i].lk, tbl[i].pl);
      end
    end

    // Saturation of both counters on the narrow instance.
    cycle(1, 1, 2'b00);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    chk("sat_trans_cnt", int'(s_tc), 3);
    chk("dut_trans_cnt", int'(d_tc), 5);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 2'b00);
    end
    chk("sat_dwell", int'(s_dw), 3);
    chk("sat_trans_hold", int'(s_tc), 3);
    chk("dut_dwell", int'(d_dw), 6);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 2'b11);
    end
    chk("sat_lock_satdw", int'(s_lk), 1);
    chk("sat_dwell_lk", int'(s_dw), 3);

    // Random traffic biased toward the target.
    for (int i = 0; i < 400; i++) begin
      bit r, e;
      bit [1:0] c;
      r = ($urandom_range(0, 39) == 0);
      e = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 1) == 1) ? TGT : 2'($urandom);
      cycle(r, e, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
